regfile_sb: RTL and testbench

- Parametrised integer register file for the pipeline: NUM_RD combinational read ports, one write-back port, and a per-register scoreboard of busy bits.
- Decode allocates a destination at issue, which marks it busy. Write-back writes the data and clears the busy bit.
- After reset, the array is cleared by a sequential sweep, one entry per cycle, rather than a single-cycle bulk clear.
- Sits between ID (read and allocate) and WB (write), replacing the fixed 2-read, 32x32 file.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_sb_score.sv | 48 ++++
 rtl/regfile_sb.sv | 134 +++++++++++++
 tb/tb_regfile_sb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : regfile_pkg                                         |
// | Description: Shared constants and state encoding for regfile_sb. |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  // Architectural zero register: hard-wired to 0, never tracked as busy.
  localparam int ZERO_REG  = 0;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_sb_score.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : regfile_sb_score                                    |
// | Description: Per-register busy scoreboard. Flush beats set, set  |
// |              beats clear, register 0 is never busy.              |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module regfile_sb_score
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: a new producer (set) overrides a completing one (clear).
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy register with synchronous clear on reset.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule : regfile_sb_score
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : regfile_sb                                          |
// | Description: Parametrised register file with NUM_RD combinational|
// |              read ports, one write-back port, busy scoreboard    |
// |              and a post-reset sequential clear sweep.            |
// |              Optional macro REGFILE_BYPASS_EN enables same-cycle |
// |              write-through forwarding to the read ports.         |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  input  logic                   flush,
  output logic                   init_done
);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            init_done_q, init_done_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            run;
  logic            wr_ok;
  logic            alloc_ok;
  logic [DEPTH-1:0] busy_vec;

  assign run      = (state_q == ST_RUN);
  assign wr_ok    = run && wr_en && (wr_addr != AW'(ZERO_REG));
  assign alloc_ok = run && alloc_en && (alloc_addr != AW'(ZERO_REG));

  // Sweep/run sequencing and selection of the single array write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    if (state_q == ST_INIT) begin
      mem_we    = !rst;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else begin
      mem_we = !rst && wr_ok;
    end
  end

  // Control state; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Register array: sweep clears and write-back share one write port.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  regfile_sb_score #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_score (
    .clk      (clk),
    .rst      (rst),
    .flush    (run && flush),
    .set_en   (alloc_ok),
    .set_addr (alloc_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .busy     (busy_vec)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rs_addr[k*AW +: AW];

    // Read mux: zero during the sweep and for register 0.
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (run && (addr != AW'(ZERO_REG))) begin
        data = mem_q[addr];
        bsy  = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == addr)) begin
          data = wr_data;
          bsy  = 1'b0;
        end
`endif
      end
    end

    assign rs_data[k*XLEN +: XLEN] = data;
    assign rs_busy[k]              = bsy;
  end

  assign init_done = init_done_q;

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : tb_regfile_sb                                       |
// | Description: Self-checking bench for regfile_sb with a          |
// |              behavioural array/scoreboard reference model.       |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_regfile_sb;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   rs_addr;
  logic [NUM_RD*XLEN-1:0] rs_data;
  logic [NUM_RD-1:0]      rs_busy;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;
  logic                   flush;
  logic                   init_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents, busy flags, sweep progress.
  logic [XLEN-1:0] m_mem  [DEPTH];
  bit              m_busy [DEPTH];
  bit              m_run = 1'b0;
  int              m_cnt = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs_addr    (rs_addr),
    .rs_data    (rs_data),
    .rs_busy    (rs_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .init_done  (init_done)
  );

  // Apply one clock edge of the architectural rules to the model.
  task automatic model_step();
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (!m_run) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end else begin
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
        if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      end
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(int k);
    logic [AW-1:0] a;
    a = rs_addr[k*AW +: AW];
    if (!m_run || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(int k);
    logic [AW-1:0] a;
    a = rs_addr[k*AW +: AW];
    if (!m_run || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    alloc_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic set_rs(input int a0, input int a1);
    rs_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'h0000_DEAD;
    set_rs(5, 0);
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (init_done !== 1'b0) begin
      n_err++; $display("FAIL reset_init_done: got %b expected 0", init_done);
    end
    for (int k = 0; k < NUM_RD; k++) begin
      n_cmp++;
      if (rs_data[k*XLEN +: XLEN] !== '0 || rs_busy[k] !== 1'b0) begin
        n_err++; $display("FAIL reset_port%0d: got data %h busy %b expected 0/0", k, rs_data[k*XLEN +: XLEN], rs_busy[k]);
      end
    end
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      if (c == DEPTH) wr_en = 1'b0;
      n_cmp++;
      if (init_done !== (c == DEPTH)) begin
        n_err++; $display("FAIL sweep_init_done cycle %0d: got %b expected %b", c, init_done, (c == DEPTH));
      end
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rs(a, a + 1);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        n_cmp++;
        if (rs_data[k*XLEN +: XLEN] !== '0 || rs_busy[k] !== 1'b0) begin
          n_err++; $display("FAIL swept_entry x%0d: got data %h busy %b expected 0/0", a + k, rs_data[k*XLEN +: XLEN], rs_busy[k]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5_0001;
    tick();
    idle();
    set_rs(7, 0);
    #1;
    n_cmp++;
    if (rs_data[0 +: XLEN] !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL write_read_x7: got %h expected a5a50001", rs_data[0 +: XLEN]);
    end
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
    tick();
    idle();
    set_rs(0, 7);
    #1;
    n_cmp++;
    if (rs_data[0 +: XLEN] !== '0 || rs_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL write_x0: got %h busy %b expected 0/0", rs_data[0 +: XLEN], rs_busy[0]);
    end
    n_cmp++;
    if (rs_data[XLEN +: XLEN] !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL x7_port1: got %h expected a5a50001", rs_data[XLEN +: XLEN]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    alloc_en = 1'b1; alloc_addr = 3;
    tick();
    idle();
    set_rs(3, 3);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (rs_busy !== 2'b11) begin
        n_err++; $display("FAIL busy_x3 cycle %0d: got %b expected 11", c, rs_busy);
      end
      if (c == 0) tick();
    end
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h42;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rs_busy !== 2'b00 || rs_data[0 +: XLEN] !== 32'h42) begin
      n_err++; $display("FAIL write_clears_x3: got busy %b data %h expected 00/00000042", rs_busy, rs_data[0 +: XLEN]);
    end
    alloc_en = 1'b1; alloc_addr = 4;
    wr_en = 1'b1; wr_addr = 4; wr_data = 32'h9;
    tick();
    idle();
    set_rs(4, 4);
    #1;
    n_cmp++;
    if (rs_busy[0] !== 1'b1 || rs_data[0 +: XLEN] !== 32'h9) begin
      n_err++; $display("FAIL alloc_write_same_x4: got busy %b data %h expected 1/00000009", rs_busy[0], rs_data[0 +: XLEN]);
    end
  endtask

  task automatic test_flush();
    idle();
    for (int r = 1; r <= 3; r++) begin
      alloc_en = 1'b1; alloc_addr = AW'(r);
      tick();
    end
    idle();
    set_rs(1, 3);
    #1;
    n_cmp++;
    if (rs_busy !== 2'b11) begin
      n_err++; $display("FAIL pre_flush_busy: got %b expected 11", rs_busy);
    end
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 6;
    tick();
    idle();
    for (int p = 0; p < 4; p++) begin
      set_rs(2 * p + 1, (p == 3) ? 6 : 2 * p + 2);
      #1;
      n_cmp++;
      if (rs_busy !== 2'b00) begin
        n_err++; $display("FAIL flush_busy pair %0d: got %b expected 00", p, rs_busy);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h5555_5555;
    alloc_en = 1'b1; alloc_addr = 9;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h1234;
    set_rs(0, 9);
    #1;
    n_cmp++;
`ifdef REGFILE_BYPASS_EN
    if (rs_data[XLEN +: XLEN] !== 32'h1234 || rs_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL bypass_same_cycle: got %h busy %b expected 00001234/0", rs_data[XLEN +: XLEN], rs_busy[1]);
    end
`else
    if (rs_data[XLEN +: XLEN] !== 32'h5555_5555 || rs_busy[1] !== 1'b1) begin
      n_err++; $display("FAIL no_bypass_same_cycle: got %h busy %b expected 55555555/1", rs_data[XLEN +: XLEN], rs_busy[1]);
    end
`endif
    tick();
    idle();
    #1;
    n_cmp++;
    if (rs_data[XLEN +: XLEN] !== 32'h1234 || rs_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL write_next_cycle: got %h busy %b expected 00001234/0", rs_data[XLEN +: XLEN], rs_busy[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en      = ($urandom % 2) == 0;
      wr_addr    = AW'($urandom);
      wr_data    = $urandom;
      alloc_en   = ($urandom % 2) == 0;
      alloc_addr = ((($urandom % 3) == 0) ? wr_addr : AW'($urandom));
      flush      = ($urandom % 16) == 0;
      set_rs($urandom % DEPTH, (($urandom % 4) == 0) ? int'(wr_addr) : int'($urandom % DEPTH));
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        n_cmp++;
        if (rs_data[k*XLEN +: XLEN] !== exp_data(k) || rs_busy[k] !== exp_busy(k)) begin
          n_err++; $display("FAIL random cycle %0d port %0d: got %h/%b expected %h/%b", c, k, rs_data[k*XLEN +: XLEN], rs_busy[k], exp_data(k), exp_busy(k));
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midsweep();
    int cycles;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cycles = 0;
    #1;
    while (init_done !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    n_cmp++;
    if (cycles != DEPTH) begin
      n_err++; $display("FAIL midsweep_restart: init_done after %0d cycles expected %0d", cycles, DEPTH);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rs(a, a + 1);
      #1;
      n_cmp++;
      if (rs_data !== '0 || rs_busy !== 2'b00) begin
        n_err++; $display("FAIL midsweep_cleared x%0d/x%0d: got %h busy %b expected 0", a, a + 1, rs_data, rs_busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; alloc_addr = '0;
    rs_addr = '0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_random();
    test_reset_midsweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_sb
`default_nettype wire
